// File: rtl/alu_issue_if.sv
// Handshake and bus bundle between the ALU issue sequencer (master) and its
// surroundings: fetch/operand source, combinational ALU, data memory, writeback.
interface alu_issue_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_instr;
    logic [7:0] in_a;
    logic [7:0] in_b;

    logic [2:0] alu_op;
    logic [2:0] alu_func;
    logic [7:0] alu_ina;
    logic [7:0] alu_inb;
    logic       alu_flag_in;
    logic       alu_overflow_in;
    logic [7:0] alu_out;
    logic       alu_flag_out;
    logic       alu_overflow_out;

    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    logic       wb_valid;
    logic       wb_ready;
    logic [7:0] wb_data;

    logic       flag;
    logic       overflow;
    logic       err;

    modport master (
        input  in_valid, in_instr, in_a, in_b,
        output in_ready,
        output alu_op, alu_func, alu_ina, alu_inb, alu_flag_in, alu_overflow_in,
        input  alu_out, alu_flag_out, alu_overflow_out,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output wb_valid, wb_data,
        input  wb_ready,
        output flag, overflow, err
    );

    modport slave (
        output in_valid, in_instr, in_a, in_b,
        input  in_ready,
        input  alu_op, alu_func, alu_ina, alu_inb, alu_flag_in, alu_overflow_in,
        output alu_out, alu_flag_out, alu_overflow_out,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  wb_valid, wb_data,
        output wb_ready,
        input  flag, overflow, err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer for the combinational ALU: owns FLAG/OVERFLOW, runs LW/SW
// over the memory port, returns results on writeback. Optional macro: ALU_CARRY_CHAIN_EN.
//
// state  | meaning
// S_IDLE | ready for a new instruction
// S_EXEC | ALU driven from latched operands, result sampled at end of cycle
// S_MEM  | memory request outstanding, timeout counter running
// S_WB   | writeback value offered until consumer accepts
module alu_issue_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    alu_issue_if.master bus
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SEI = 3'd2;
    localparam logic [2:0] OP_SHF = 3'd3;
    localparam logic [2:0] OP_CEQ = 3'd4;
    localparam logic [2:0] OP_CLT = 3'd5;
    localparam logic [2:0] OP_LW  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

    state_t     state_q;
    logic [2:0] op_q;
    logic [2:0] func_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       flag_q;
    logic       ovf_q;
    logic       err_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic [7:0] mem_addr_q;
    logic [7:0] mem_wdata_q;
    logic       wb_valid_q;
    logic [7:0] wb_data_q;
    logic [7:0] cnt_q;
    logic       ovf_in;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            func_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            flag_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.in_instr[8:6];
                        func_q  <= bus.in_instr[2:0];
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_CEQ, OP_CLT: begin
                            flag_q  <= bus.alu_flag_out;
                            ovf_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                        OP_LW, OP_SW: begin
                            mem_addr_q  <= bus.alu_out;
                            mem_wdata_q <= a_q;
                            mem_we_q    <= (op_q == OP_SW);
                            ovf_q       <= 1'b0;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            state_q     <= S_MEM;
                        end
                        default: begin
                            wb_data_q  <= bus.alu_out;
                            ovf_q      <= bus.alu_overflow_out;
                            wb_valid_q <= 1'b1;
                            state_q    <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    // An ack arriving on the last allowed cycle still completes the access.
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (op_q == OP_LW) begin
                            wb_data_q  <= bus.mem_rdata;
                            wb_valid_q <= 1'b1;
                            state_q    <= S_WB;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WB: begin
                    if (bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Shifts always see the OVERFLOW register; add/sub only when chaining is enabled.
    always_comb begin
        ovf_in = 1'b0;
        case (op_q)
            OP_SHF: ovf_in = ovf_q;
`ifdef ALU_CARRY_CHAIN_EN
            OP_ADD, OP_SUB: ovf_in = ovf_q;
`else
            OP_ADD, OP_SUB: ovf_in = 1'b0;
`endif
            default: ovf_in = 1'b0;
        endcase
    end

    assign bus.in_ready        = (state_q == S_IDLE) && !reset_i;
    assign bus.alu_op          = op_q;
    assign bus.alu_func        = func_q;
    assign bus.alu_ina         = a_q;
    assign bus.alu_inb         = b_q;
    assign bus.alu_flag_in     = flag_q;
    assign bus.alu_overflow_in = ovf_in;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.wb_valid        = wb_valid_q;
    assign bus.wb_data         = wb_data_q;
    assign bus.flag            = flag_q;
    assign bus.overflow        = ovf_q;
    assign bus.err             = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU and a scripted memory.
module tb_alu_issue_ctrl;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SEI = 3'd2;
    localparam logic [2:0] OP_SHF = 3'd3;
    localparam logic [2:0] OP_CEQ = 3'd4;
    localparam logic [2:0] OP_CLT = 3'd5;
    localparam logic [2:0] OP_LW  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    alu_issue_if bus ();

    alu_issue_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        logic [8:0] sum;
        sum = '0;
        bus.alu_out          = '0;
        bus.alu_flag_out     = 1'b0;
        bus.alu_overflow_out = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                sum = {1'b0, bus.alu_ina} + {1'b0, bus.alu_inb} + {8'd0, bus.alu_overflow_in};
                {bus.alu_overflow_out, bus.alu_out} = sum;
            end
            OP_SUB: begin
                sum = {1'b0, bus.alu_ina} - {1'b0, bus.alu_inb} - {8'd0, bus.alu_overflow_in};
                {bus.alu_overflow_out, bus.alu_out} = sum;
            end
            OP_SEI: bus.alu_out = bus.alu_inb;
            OP_SHF: begin
                bus.alu_out          = {bus.alu_ina[6:0], bus.alu_overflow_in};
                bus.alu_overflow_out = bus.alu_ina[7];
            end
            OP_CEQ: bus.alu_flag_out = (bus.alu_ina == bus.alu_inb);
            OP_CLT: bus.alu_flag_out = (bus.alu_ina < bus.alu_inb);
            default: bus.alu_out = bus.alu_inb;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issues one instruction and observes it until the sequencer is ready again.
    // ack_at: MEM_REQ cycle on which to acknowledge (0 = never).
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int ack_at, input logic [7:0] rdata,
                          output int wb_lat, output logic [7:0] wbd, output int req_n,
                          output logic [7:0] addr, output logic we, output logic [7:0] wd,
                          output logic mem_stable, output int rdy_lat);
        wb_lat = 0; wbd = '0; req_n = 0; addr = '0; we = 1'b0; wd = '0;
        mem_stable = 1'b1; rdy_lat = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = {op, 6'b000000};
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        for (int lat = 1; lat <= 30 && rdy_lat == 0; lat++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.mem_ack  = 1'b0;
            if (bus.mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    addr = bus.mem_addr; we = bus.mem_we; wd = bus.mem_wdata;
                end else if (bus.mem_addr !== addr || bus.mem_we !== we || bus.mem_wdata !== wd) begin
                    mem_stable = 1'b0;
                end
                if (req_n == ack_at) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            if (bus.wb_valid && wb_lat == 0) begin
                wb_lat = lat;
                wbd    = bus.wb_data;
            end
            if (bus.in_ready) rdy_lat = lat;
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int         wb_lat, req_n, rdy_lat;
        logic [7:0] wbd, addr, wd;
        logic       we, stable;
        logic [7:0] exp_chain;

        n_chk = 0; n_fail = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_a = '0; bus.in_b = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0; bus.wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_outs", {bus.wb_valid, bus.mem_req, bus.flag, bus.overflow, bus.err}, 0);
        chk("rst_alu", {bus.alu_op, bus.alu_func, bus.alu_ina, bus.alu_inb}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 1);

        run_op(OP_ADD, 8'hF0, 8'h20, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("add_wb_lat", wb_lat, 2);
        chk("add_wb_data", 32'(wbd), 32'h10);
        chk("add_ready_lat", rdy_lat, 3);
        chk("add_ovf", 32'(bus.overflow), 1);

        run_op(OP_SHF, 8'h81, 8'h00, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("shf_wb_data", 32'(wbd), 32'h03);
        chk("shf_ovf", 32'(bus.overflow), 1);

`ifdef ALU_CARRY_CHAIN_EN
        exp_chain = 8'h03;
`else
        exp_chain = 8'h02;
`endif
        run_op(OP_ADD, 8'h01, 8'h01, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("add_chain_data", 32'(wbd), 32'(exp_chain));
        chk("add_chain_ovf", 32'(bus.overflow), 0);

        run_op(OP_CEQ, 8'h55, 8'h55, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("ceq_flag", 32'(bus.flag), 1);
        chk("ceq_no_wb", wb_lat, 0);
        chk("ceq_ready_lat", rdy_lat, 2);

        run_op(OP_CLT, 8'h09, 8'h03, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("clt_flag", 32'(bus.flag), 0);
        chk("clt_no_wb", wb_lat, 0);

        run_op(OP_LW, 8'h00, 8'h3C, 4, 8'hA7, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("lw_addr", 32'(addr), 32'h3C);
        chk("lw_we", 32'(we), 0);
        chk("lw_stable", 32'(stable), 1);
        chk("lw_req_cycles", req_n, 4);
        chk("lw_wb_data", 32'(wbd), 32'hA7);
        chk("lw_wb_lat", wb_lat, 6);
        chk("lw_ack_wins_err", 32'(bus.err), 0);

        run_op(OP_LW, 8'h00, 8'h12, 1, 8'h5E, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("lw_fast_wb_lat", wb_lat, 3);
        chk("lw_fast_data", 32'(wbd), 32'h5E);

        run_op(OP_SW, 8'h11, 8'h40, 1, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("sw_addr", 32'(addr), 32'h40);
        chk("sw_we", 32'(we), 1);
        chk("sw_wdata", 32'(wd), 32'h11);
        chk("sw_no_wb", wb_lat, 0);
        chk("sw_ready_lat", rdy_lat, 3);

        run_op(OP_SW, 8'h22, 8'h50, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("tmo_req_cycles", req_n, 4);
        chk("tmo_err", 32'(bus.err), 1);
        chk("tmo_no_wb", wb_lat, 0);
        chk("tmo_ready_lat", rdy_lat, 6);
        chk("tmo_req_low", 32'(bus.mem_req), 0);

        run_op(OP_CEQ, 8'h55, 8'h55, 0, 8'h00, wb_lat, wbd, req_n, addr, we, wd, stable, rdy_lat);
        chk("ceq2_flag", 32'(bus.flag), 1);

        // Writeback stall, then reset while the result is still pending
        bus.wb_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_instr = {OP_ADD, 6'b000000};
        bus.in_a = 8'hF0; bus.in_b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stall_wb_valid0", 32'(bus.wb_valid), 1);
        chk("stall_ovf", 32'(bus.overflow), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {bus.wb_valid, bus.in_ready, bus.wb_data}, {1'b1, 1'b0, 8'h10});
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_mid_regs", {bus.flag, bus.overflow, bus.err, bus.mem_req}, 0);
        reset = 1'b0;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
